// File: rtl/countdown_display_scan_if.sv
// Display-side signal bundle for the countdown scanner.
// The master drives the BCD digits and the timing/status strobes.
// The slave returns the multiplexed anode/segment pins.
interface countdown_display_scan_if;
    logic [3:0] value_three;
    logic [3:0] value_two;
    logic [3:0] value_one;
    logic       sec_timer;
    logic       running;
    logic [2:0] an;
    logic [6:0] seg;

    modport master (
        output value_three, value_two, value_one, sec_timer, running,
        input  an, seg
    );

    modport slave (
        input  value_three, value_two, value_one, sec_timer, running,
        output an, seg
    );
endinterface

// File: rtl/countdown_display_scan.sv
// Three-digit common-anode seven-segment scanner for the countdown timer.
// Features:
//   - Per-frame shadowing of the BCD inputs, so a frame never tears.
//   - Leading-zero blanking.
//   - A dash glyph for non-BCD digits.
//   - A 1 Hz blink warning when the running value is low but not yet zero.
// The an/seg pins are registered from next-state values, so they switch on the same edge as the slot index.
module countdown_display_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter logic [11:0] BLINK_THRESH = 12'h010
) (
    input  logic                      clk,
    input  logic                      reset,
    countdown_display_scan_if.slave   dsp
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    // Active-low segment pattern {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h3F;
        endcase
        return pattern;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [11:0]      shadow_q, shadow_d;
    logic             blink_phase_q, blink_phase_d;
    logic [2:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             blink_cond_s;
    logic             blank_s;
    logic [3:0]       digit_s;
    logic [2:0]       slot_an_s;

    // Next-state logic for the scan counter, the shadow digits, the blink phase and the pin images.
    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        blink_phase_d = 1'b0;
        blink_cond_s  = 1'b0;
        blank_s       = 1'b1;
        digit_s       = 4'd0;
        slot_an_s     = 3'b111;
        an_d          = 3'b111;
        seg_d         = 7'h7F;

        // Slot advance; new digits are captured only when a whole frame has completed.
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (idx_q == 2'd2) begin
                idx_d    = 2'd0;
                shadow_d = {dsp.value_three, dsp.value_two, dsp.value_one};
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Blink is judged on the value being shown next, so a boundary pulse sees the fresh digits.
        blink_cond_s = dsp.running && (shadow_d != 12'h000) && (shadow_d < BLINK_THRESH);
        if (blink_cond_s) begin
            blink_phase_d = dsp.sec_timer ? ~blink_phase_q : blink_phase_q;
        end else begin
            blink_phase_d = 1'b0;
        end

        // A non-BCD leading digit counts as nonzero, so it is shown rather than blanked.
        case (idx_d)
            2'd0: begin
                digit_s   = shadow_d[3:0];
                slot_an_s = 3'b110;
                blank_s   = 1'b0;
            end
            2'd1: begin
                digit_s   = shadow_d[7:4];
                slot_an_s = 3'b101;
                blank_s   = (shadow_d[11:8] == 4'd0) && (shadow_d[7:4] == 4'd0);
            end
            2'd2: begin
                digit_s   = shadow_d[11:8];
                slot_an_s = 3'b011;
                blank_s   = (shadow_d[11:8] == 4'd0);
            end
            default: begin
                digit_s   = 4'd0;
                slot_an_s = 3'b111;
                blank_s   = 1'b1;
            end
        endcase

        if (blank_s || blink_phase_d) begin
            an_d  = 3'b111;
            seg_d = 7'h7F;
        end else begin
            an_d  = slot_an_s;
            seg_d = seg_decode(digit_s);
        end
    end

    // State and pin registers; reset drops the current frame immediately and darkens the display.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            shadow_q      <= 12'h000;
            blink_phase_q <= 1'b0;
            an_q          <= 3'b111;
            seg_q         <= 7'h7F;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign dsp.an  = an_q;
    assign dsp.seg = seg_q;

endmodule

// File: tb/tb_countdown_display_scan.sv
// Directed bench for countdown_display_scan with SCAN_DIV=4.
// Stimulus pushes {cycle, an, seg} expectations into a queue.
// A monitor on the falling edge compares the pins whenever an expectation comes due.
// Cycle r is the r-th rising edge after reset was last applied.
// r=0 is the reset edge itself.
module tb_countdown_display_scan;

    localparam int SD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    countdown_display_scan_if dif ();

    countdown_display_scan #(
        .SCAN_DIV     (SD),
        .BLINK_THRESH (12'h010)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dsp   (dif)
    );

    typedef struct {
        int         abs_cyc;
        logic [2:0] an;
        logic [6:0] seg;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tcyc     = 0;
    int   base     = 0;
    int   checks   = 0;
    int   failures = 0;

    // Absolute count of rising edges since time zero.
    always @(posedge clk) tcyc <= tcyc + 1;

    // Monitor: compare the due expectation, or flag one that was skipped.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            if (exp_q[0].abs_cyc < tcyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                         mon_e.name, mon_e.abs_cyc, tcyc);
            end else if (exp_q[0].abs_cyc == tcyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (dif.an !== mon_e.an || dif.seg !== mon_e.seg) begin
                    failures++;
                    $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
                             mon_e.name, dif.an, dif.seg, mon_e.an, mon_e.seg);
                end
            end
        end
    end

    task automatic expect_at(input int rel, input logic [2:0] a, input logic [6:0] s,
                             input string n);
        exp_t e;
        e.abs_cyc = base + rel;
        e.an      = a;
        e.seg     = s;
        e.name    = n;
        exp_q.push_back(e);
    endtask

    task automatic wait_rel(input int rel);
        do @(negedge clk); while (tcyc < base + rel);
    endtask

    task automatic apply(input int rel, input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] o, input logic run);
        wait_rel(rel);
        dif.value_three = h;
        dif.value_two   = t;
        dif.value_one   = o;
        dif.running     = run;
    endtask

    task automatic pulse(input int rel);
        wait_rel(rel);
        dif.sec_timer = 1'b1;
        @(negedge clk);
        dif.sec_timer = 1'b0;
    endtask

    initial begin
        dif.value_three = 4'd1;
        dif.value_two   = 4'd2;
        dif.value_one   = 4'd3;
        dif.sec_timer   = 1'b0;
        dif.running     = 1'b0;

        // Reset is held through edge 3, so that edge is r=0.
        base = 3;
        expect_at(0, 3'b111, 7'h7F, "reset_state");
        expect_at(1, 3'b110, 7'h40, "first_edge_ones_0");
        expect_at(5, 3'b111, 7'h7F, "frame0_tens_blank");
        expect_at(9, 3'b111, 7'h7F, "frame0_hund_blank");
        wait_rel(0);
        reset = 1'b0;

        // Digits applied mid-frame take effect at the next frame boundary.
        apply(6, 4'd1, 4'd2, 4'd3, 1'b0);
        expect_at(13, 3'b110, 7'h30, "v123_ones");
        expect_at(17, 3'b101, 7'h24, "v123_tens");
        expect_at(21, 3'b011, 7'h79, "v123_hund");

        apply(18, 4'd0, 4'd0, 4'd7, 1'b0);
        expect_at(25, 3'b110, 7'h78, "v007_ones");
        expect_at(29, 3'b111, 7'h7F, "v007_tens_blank");
        expect_at(33, 3'b111, 7'h7F, "v007_hund_blank");

        apply(30, 4'd0, 4'd5, 4'd0, 1'b0);
        expect_at(37, 3'b110, 7'h40, "v050_ones");
        expect_at(41, 3'b101, 7'h12, "v050_tens");
        expect_at(45, 3'b111, 7'h7F, "v050_hund_blank");

        apply(42, 4'd1, 4'hC, 4'd4, 1'b0);
        expect_at(49, 3'b110, 7'h19, "v1C4_ones");
        expect_at(53, 3'b101, 7'h3F, "v1C4_tens_dash");
        expect_at(57, 3'b011, 7'h79, "v1C4_hund");

        apply(54, 4'hA, 4'd0, 4'd0, 1'b0);
        expect_at(61, 3'b110, 7'h40, "vA00_ones");
        expect_at(65, 3'b101, 7'h40, "vA00_tens_not_blank");
        expect_at(69, 3'b011, 7'h3F, "vA00_hund_dash");

        // A zero value while running shows a steady zero; sec_timer has no effect.
        apply(66, 4'd0, 4'd0, 4'd0, 1'b1);
        expect_at(73, 3'b110, 7'h40, "v000_run_ones");
        expect_at(75, 3'b110, 7'h40, "v000_after_pulse");
        expect_at(77, 3'b111, 7'h7F, "v000_tens_blank");
        pulse(74);

        // A value equal to the threshold does not blink.
        apply(78, 4'd0, 4'd1, 4'd0, 1'b1);
        expect_at(85, 3'b110, 7'h40, "v010_ones");
        expect_at(87, 3'b110, 7'h40, "v010_no_blink");
        expect_at(89, 3'b101, 7'h79, "v010_tens");
        pulse(86);

        // The pulse lands on the boundary edge and uses the newly loaded 009.
        apply(90, 4'd0, 4'd0, 4'd9, 1'b1);
        expect_at(97, 3'b111, 7'h7F, "boundary_pulse_blink");
        pulse(95);
        pulse(100);

        apply(102, 4'd0, 4'd0, 4'd9, 1'b1);
        expect_at(109, 3'b110, 7'h10, "v009_unblinked");
        expect_at(111, 3'b111, 7'h7F, "v009_blink_on");
        pulse(110);

        // The blink phase holds across a boundary, then clears when running drops.
        apply(114, 4'd0, 4'd0, 4'd5, 1'b1);
        expect_at(121, 3'b111, 7'h7F, "v005_blink_held");
        expect_at(122, 3'b110, 7'h12, "v005_stop_clears_blink");
        wait_rel(121);
        dif.running = 1'b0;

        apply(126, 4'd0, 4'd0, 4'd3, 1'b0);
        expect_at(133, 3'b110, 7'h30, "v003_idle_no_blink");
        pulse(131);

        apply(138, 4'd0, 4'd0, 4'd2, 1'b1);
        expect_at(145, 3'b111, 7'h7F, "v002_blink_on");
        expect_at(149, 3'b111, 7'h7F, "v002_tens_dark");
        pulse(144);

        // Reset at idx=2, cnt=2 with blink active.
        wait_rel(154);
        reset = 1'b1;
        base  = tcyc + 1;
        expect_at(0, 3'b111, 7'h7F, "midscan_reset_dark");
        expect_at(1, 3'b110, 7'h40, "midscan_reset_restart");
        expect_at(13, 3'b110, 7'h24, "post_reset_v002");
        expect_at(15, 3'b110, 7'h24, "no_tearing_mid_frame");
        expect_at(25, 3'b110, 7'h00, "v008_next_frame");
        wait_rel(0);
        reset = 1'b0;
        apply(14, 4'd0, 4'd0, 4'd8, 1'b1);

        wait_rel(26);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
